video_source_scheduler: RTL

- Frame-synchronous scheduler between two 24-bit pixel sources (test pattern generator, image pipeline) and the DVI controller's Video/VideoReady/VideoValid interface.
- Tracks the current pixel position by counting accepted transfers.
- Switches the active source or enable state only at frame boundaries.
- Substitutes a fill colour on source underflow and counts underflows, so the DVI stream never stalls or loses frame alignment.

---
 rtl/video_source_scheduler.sv | 128 ++++++++++++
 1 files changed

// File: rtl/video_source_scheduler.sv
// rtl/video_source_scheduler.sv - frame-synchronous two-source pixel scheduler feeding the DVI stream
// Position tracks accepted transfers; source/enable changes only land on the last pixel of a frame.
module video_source_scheduler #(
  parameter int          Width     = 1040,
  parameter int          Height    = 666,
  parameter int          XWidth    = 11,
  parameter int          YWidth    = 10,
  parameter logic [23:0] FillColor = 24'h000000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic              src_sel_i,
  input  logic [23:0]       src0_data_i,
  input  logic              src0_valid_i,
  output logic              src0_ready_o,
  input  logic [23:0]       src1_data_i,
  input  logic              src1_valid_i,
  output logic              src1_ready_o,
  output logic [23:0]       video_o,
  output logic              video_valid_o,
  input  logic              video_ready_i,
  output logic              active_src_o,
  output logic              streaming_o,
  output logic [XWidth-1:0] pixel_x_o,
  output logic [YWidth-1:0] pixel_y_o,
  output logic              frame_start_o,
  output logic [15:0]       underflow_count_o
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_STREAM = 1'b1;

  logic [0:0]        state_q, state_d;
  logic              active_src_q, active_src_d;
  logic [XWidth-1:0] x_q, x_d;
  logic [YWidth-1:0] y_q, y_d;
  logic [15:0]       uf_q, uf_d;

  logic        xfer;
  logic        last_x;
  logic        last_y;
  logic        boundary;
  logic        stream;
  logic        sel_valid;
  logic [23:0] sel_data;
  logic        underflow;

  // The DVI must never be starved, so a pixel (real or fill) is always on offer.
  assign video_valid_o = 1'b1;
  assign xfer          = video_valid_o & video_ready_i;

  assign last_x   = (x_q == XWidth'(Width - 1));
  assign last_y   = (y_q == YWidth'(Height - 1));
  assign boundary = xfer & last_x & last_y;

  assign stream    = (state_q == ST_STREAM);
  assign sel_valid = active_src_q ? src1_valid_i : src0_valid_i;
  assign sel_data  = active_src_q ? src1_data_i  : src0_data_i;
  assign underflow = stream & video_ready_i & ~sel_valid;

  assign video_o      = (stream & sel_valid) ? sel_data : FillColor;
  assign src0_ready_o = stream & ~active_src_q & video_ready_i & src0_valid_i;
  assign src1_ready_o = stream &  active_src_q & video_ready_i & src1_valid_i;

  assign active_src_o      = active_src_q;
  assign streaming_o       = stream;
  assign pixel_x_o         = x_q;
  assign pixel_y_o         = y_q;
  assign frame_start_o     = xfer & (x_q == '0) & (y_q == '0);
  assign underflow_count_o = uf_q;

  always_comb begin
    state_d      = state_q;
    active_src_d = active_src_q;
    x_d          = x_q;
    y_d          = y_q;
    uf_d         = uf_q;

    if (xfer) begin
      if (last_x) begin
        x_d = '0;
        y_d = last_y ? '0 : y_q + YWidth'(1);
      end else begin
        x_d = x_q + XWidth'(1);
      end
    end

    if (boundary) begin
      case (state_q)
        ST_IDLE: begin
          if (enable_i) begin
            state_d      = ST_STREAM;
            active_src_d = src_sel_i;
          end
        end
        default: begin
          if (enable_i) begin
            active_src_d = src_sel_i;
          end else begin
            state_d = ST_IDLE;
          end
        end
      endcase
    end

    if (underflow && (uf_q != 16'hFFFF)) begin
      uf_d = uf_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      active_src_q <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      uf_q         <= '0;
    end else begin
      state_q      <= state_d;
      active_src_q <= active_src_d;
      x_q          <= x_d;
      y_q          <= y_d;
      uf_q         <= uf_d;
    end
  end

endmodule
